// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// Purpose : sequences PLL reset, waits for a stable lock, then releases the PLL-domain reset.
// Latency : locked is seen 2 cycles after it changes; every output is registered from the next state.
// Backpressure: none; retry is a single-cycle request that is honoured only in FAILED.
//
// Ports:
//   clock_in        free-running reference clock, the only clock
//   reset           asynchronous, active-high reset
//   locked          PLL LOCK, asynchronous to clock_in
//   retry           single-cycle request to leave FAILED
//   pll_resetb      PLL RESETB, active low
//   sys_reset       active-high reset for logic in the PLL output domain
//   ready           high only in RUN
//   fail            high only in FAILED
//   lock_lost_count lock losses seen in RUN, saturates at 255
//   state           PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4
module pll_lock_supervisor #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    input  logic       retry,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lock_lost_count,
    output logic [2:0] state
);

    // One shared counter sized to hold the largest terminal value (parameter - 1).
    localparam int MAX_A = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P);

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAILED    = 3'd4
    } st_t;

    st_t           st;
    st_t           st_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    retry_cnt;
    logic [3:0]    retry_inc;
    logic          lock_meta;
    logic          locked_s;
    logic          lost_evt;
    logic          timeout_hit;

    // Two-flop synchronizer; nothing downstream looks at the raw locked input.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= locked;
            locked_s  <= lock_meta;
        end
    end

    always_comb begin
        st_nxt      = st;
        retry_inc   = retry_cnt + 4'd1;
        lost_evt    = 1'b0;
        timeout_hit = 1'b0;
        case (st)
            S_PLL_RST: begin
                if (cnt == RST_LAST) st_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock arriving in the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    st_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    st_nxt      = (retry_inc == RETRY_LIMIT) ? S_FAILED : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!locked_s)                st_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  st_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    st_nxt   = S_PLL_RST;
                    lost_evt = 1'b1;
                end
            end
            S_FAILED: begin
                if (retry) st_nxt = S_PLL_RST;
            end
            default: st_nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            st              <= S_PLL_RST;
            cnt             <= '0;
            retry_cnt       <= 4'd0;
            lock_lost_count <= 8'd0;
            pll_resetb      <= 1'b0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fail            <= 1'b0;
        end else begin
            st <= st_nxt;

            // Counter restarts on every transition; it only runs in the timed states.
            if (st_nxt != st) begin
                cnt <= '0;
            end else if (st == S_PLL_RST || st == S_WAIT_LOCK || st == S_STABLE) begin
                cnt <= cnt + CW'(1);
            end

            if (timeout_hit) begin
                retry_cnt <= retry_inc;
            end else if ((st_nxt == S_RUN && st != S_RUN) || (st == S_FAILED && retry)) begin
                retry_cnt <= 4'd0;
            end

            if (lost_evt && lock_lost_count != 8'hFF) begin
                lock_lost_count <= lock_lost_count + 8'd1;
            end

            // Outputs are decoded from the next state so they move with the state register.
            pll_resetb <= !(st_nxt == S_PLL_RST || st_nxt == S_FAILED);
            sys_reset  <= (st_nxt != S_RUN);
            ready      <= (st_nxt == S_RUN);
            fail       <= (st_nxt == S_FAILED);
        end
    end

    assign state = st;

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RESET_CYCLES, default 16: cycles pll_resetb is held low per PLL reset pulse (min 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before a retry (min 2).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (min 2).
REQ-004 SHALL have parameter MAX_RETRIES, default 4: lock timeouts tolerated before FAILED (1..15).
REQ-005 SHALL have port clock_in  input  1  free-running reference clock, the only clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port locked  input  1  PLL LOCK, asynchronous to clock_in.
REQ-008 SHALL have port retry  input  1  single-cycle request to leave FAILED.
REQ-009 SHALL have port pll_resetb  output  1  drives PLL RESETB, active low.
REQ-010 SHALL have port sys_reset  output  1  active-high reset for logic in the PLL output domain.
REQ-011 SHALL have port ready  output  1  high only in RUN.
REQ-012 SHALL have port fail  output  1  high only in FAILED.
REQ-013 SHALL have port lock_lost_count  output  8  count of lock losses seen in RUN.
REQ-014 SHALL have port state  output  3  encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4.

Function
REQ-015 SHALL pass locked through a 2-flop synchronizer (locked_s); all decisions SHALL use locked_s only.
REQ-016 SHALL keep one cycle counter, cleared on every state transition and sized for the largest parameter minus 1.
REQ-017 PLL_RST: pll_resetb=0; exit to WAIT_LOCK when counter == PLL_RESET_CYCLES-1, so pll_resetb is low for exactly PLL_RESET_CYCLES cycles.
REQ-018 WAIT_LOCK: pll_resetb=1; locked_s=1 -> STABLE; otherwise, at counter == LOCK_TIMEOUT_CYCLES-1, retry_cnt increments and the FSM goes to FAILED if the new value == MAX_RETRIES, else to PLL_RST.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK, with no retry_cnt change; locked_s=1 with counter == LOCK_STABLE_CYCLES-1 -> RUN.
REQ-020 RUN: sys_reset=0 and ready=1; retry_cnt is cleared on entry; locked_s=0 -> PLL_RST, and lock_lost_count increments, saturating at 255.
REQ-021 FAILED: pll_resetb=0, sys_reset=1, fail=1; retry=1 -> PLL_RST with retry_cnt cleared; retry SHALL be ignored in all other states.
REQ-022 SHALL hold sys_reset=1 in every state except RUN.
REQ-023 SHALL register all outputs so they change only on clock_in rising edges, derived from the registered state.
REQ-024 SHALL take the RUN exit and the lock_lost_count increment in the same cycle; no lock-loss event is dropped, apart from saturation.
REQ-025 At a simultaneous timeout and locked_s rise in WAIT_LOCK, lock SHALL win and the FSM SHALL go to STABLE.

Reset
REQ-026 While reset=1: state=PLL_RST, counter=0, retry_cnt=0, lock_lost_count=0, pll_resetb=0, sys_reset=1, ready=0, fail=0.
REQ-027 Reset SHALL take effect immediately and asynchronously, from any state including mid-count.
REQ-028 Deassertion SHALL be sampled on clock_in, and the PLL_RST count SHALL begin at the first rising edge after release.
REQ-029 The synchronizer flops SHALL reset to 0.

Verification
All scenarios use PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-030 Clean lock.
- Stimulus: release reset; assert locked 3 cycles after pll_resetb rises.
- Response: pll_resetb low for exactly 4 cycles; ready=1 and sys_reset=0 exactly 2+8 cycles after locked rises, giving state sequence 0,1,2,3.
REQ-031 Lock glitch in STABLE.
- Stimulus: drop locked for 1 cycle at stable-count 5.
- Response: state returns to 1, then restarts a full 8-cycle STABLE count; ready never pulses early.
REQ-032 Timeout to FAILED.
- Stimulus: keep locked=0 throughout.
- Response: two 32-cycle WAIT_LOCK windows separated by one 4-cycle PLL_RST, then state=4, fail=1, pll_resetb=0.
- Then pulse retry: state=0 and fail=0 on the next cycle.
REQ-033 Lock loss in RUN.
- Stimulus: reach RUN, then drop locked.
- Response: 2 cycles later state=0, ready=0, sys_reset=1, lock_lost_count=1.
- Repeat 300 times: lock_lost_count saturates at 255.
REQ-034 Asynchronous reset mid-operation.
- Stimulus: assert reset between clock edges while in RUN, or at WAIT_LOCK count 20.
- Response: outputs take reset values without waiting for a clock edge; lock_lost_count=0; timing after release matches REQ-030.
